// File: rtl/my_mem_pkg.sv
// Shared definitions for the parity memory initiator and the memory model.
package my_mem_pkg;

  localparam int DATA_W  = 8;
  localparam int WORD_W  = 9;
  localparam int PAR_BIT = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_PULSE = 3'd1,
    WR_GAP   = 3'd2,
    RD_WAIT  = 3'd3,
    RD_GAP   = 3'd4,
    RESP     = 3'd5
  } state_e;

  // Parity bit that gives the stored 9-bit word an even number of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/my_mem_lat_counter.sv
// Read latency counter: load starts the count at 1, enable advances it and
// it parks on the terminal value so tc_o stays high until the next load.
module my_mem_lat_counter #(
  parameter int READ_LATENCY = 8,
  parameter int CNT_LW       = $clog2(READ_LATENCY + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_LW-1:0] TC_VAL  = CNT_LW'(READ_LATENCY);
  localparam logic [CNT_LW-1:0] ONE_VAL = CNT_LW'(1);

  logic [CNT_LW-1:0] count_q;
  logic [CNT_LW-1:0] count_d;

  assign tc_o = (count_q == TC_VAL);

  // Next count: load wins, otherwise step while enabled and not yet terminal.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = ONE_VAL;
    end else if (en_i && !tc_o) begin
      count_d = count_q + ONE_VAL;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/my_mem_initiator.sv
// Bus initiator for the parity memory model: converts a valid/ready command
// stream into write pulses / read levels and returns checked read data.
module my_mem_initiator
  import my_mem_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 8,
  parameter int CNT_W        = 16
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_perr,
  output logic [CNT_W-1:0]    perr_count,
  output logic                mem_write,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [WORD_W-1:0]   mem_data_out
);

  state_e              state_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_perr_q;
  logic [CNT_W-1:0]    perr_count_q;
  logic                mem_write_q;
  logic                mem_read_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_data_in_q;

  logic accept;
  logic lat_tc;
  logic word_perr;

  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

  // Odd number of ones in the 9-bit word means the stored parity is wrong.
  assign word_perr = mem_data_out[PAR_BIT] ^ even_parity(mem_data_out[DATA_W-1:0]);

  my_mem_lat_counter #(
    .READ_LATENCY (READ_LATENCY)
  ) u_lat (
    .clk_i  (pclk),
    .rst_i  (reset),
    .load_i (accept && !req_write),
    .en_i   (state_q == RD_WAIT),
    .tc_o   (lat_tc)
  );

  // Command FSM with all bus-facing outputs registered.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_perr_q    <= 1'b0;
      perr_count_q  <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q   <= 1'b0;
            mem_address_q <= req_addr;
            mem_data_in_q <= req_wdata;
            if (req_write) begin
              mem_write_q <= 1'b1;
              state_q     <= WR_PULSE;
            end else begin
              mem_read_q  <= 1'b1;
              state_q     <= RD_WAIT;
            end
          end
        end
        WR_PULSE: begin
          // Memory is edge triggered: guarantee a low cycle before the next write.
          mem_write_q <= 1'b0;
          state_q     <= WR_GAP;
        end
        WR_GAP: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        RD_WAIT: begin
          if (lat_tc) begin
            rsp_rdata_q <= mem_data_out[DATA_W-1:0];
            rsp_perr_q  <= word_perr;
            if (word_perr && (perr_count_q != {CNT_W{1'b1}})) begin
              perr_count_q <= perr_count_q + 1'b1;
            end
            mem_read_q <= 1'b0;
            state_q    <= RD_GAP;
          end
        end
        RD_GAP: begin
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_perr    = rsp_perr_q;
  assign perr_count  = perr_count_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_my_mem_initiator.sv
// Scoreboard bench for my_mem_initiator with a small parity memory model.
module tb_my_mem_initiator;
  import my_mem_pkg::*;

  localparam int ADDR_W = 16;
  localparam int L      = 8;
  localparam int CNT_W  = 2;

  logic              pclk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [7:0]        req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [7:0]        rsp_rdata;
  logic              rsp_perr;
  logic [CNT_W-1:0]  perr_count;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_data_in;
  logic [8:0]        mem_data_out;

  always #5 pclk = ~pclk;

  my_mem_initiator #(
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (L),
    .CNT_W        (CNT_W)
  ) dut (
    .pclk         (pclk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_perr     (rsp_perr),
    .perr_count   (perr_count),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Memory model: stores data with even parity on the rising write strobe.
  logic [8:0] mem [0:255];
  logic       force_en = 1'b0;
  logic [8:0] force_val = 9'h000;

  always @(posedge mem_write) mem[mem_address[7:0]] <= {even_parity(mem_data_in), mem_data_in};
  assign mem_data_out = force_en ? force_val : (mem_read ? mem[mem_address[7:0]] : 9'h000);

  int n_pass = 0;
  int n_total = 0;
  int ncyc = 0;

  always @(posedge pclk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct { logic [15:0] addr; logic [7:0] data; int acc; } wexp_t;
  typedef struct { logic [7:0] rdata; logic perr; logic [CNT_W-1:0] cnt; int acc; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];

  // Monitor: checks write strobes and read responses against queued expectations.
  logic prev_mw = 1'b0;
  logic prev_rv = 1'b0;
  always @(negedge pclk) begin
    wexp_t we;
    rexp_t re;
    if (mem_write) begin
      check("mw_low_gap", {31'd0, prev_mw}, 32'd0);
      check("wr_pending", {31'd0, wq.size() != 0}, 32'd1);
      if (wq.size() != 0) begin
        we = wq.pop_front();
        check("wr_addr", {16'd0, mem_address}, {16'd0, we.addr});
        check("wr_data", {24'd0, mem_data_in}, {24'd0, we.data});
        check("wr_timing", ncyc, we.acc + 1);
      end
    end
    if (rsp_valid && !prev_rv) begin
      check("rsp_pending", {31'd0, rq.size() != 0}, 32'd1);
      if (rq.size() != 0) check("rsp_latency", ncyc, rq[0].acc + L + 2);
    end
    if (rsp_valid && rsp_ready && rq.size() != 0) begin
      re = rq.pop_front();
      check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, re.rdata});
      check("rsp_perr", {31'd0, rsp_perr}, {31'd0, re.perr});
      check("perr_count", {30'd0, perr_count}, {30'd0, re.cnt});
    end
    prev_mw <= mem_write;
    prev_rv <= rsp_valid;
  end

  // Issue one command; called and returns just after a rising edge.
  task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] er, input logic ep, input logic [CNT_W-1:0] ec,
                        input bit expect_rsp, input bit keep, output int acc);
    int budget;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    budget = 0;
    @(negedge pclk);
    while (!req_ready && budget < 60) begin budget++; @(negedge pclk); end
    if (!req_ready) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      @(posedge pclk); #1;
      return;
    end
    acc = ncyc;
    if (wr) wq.push_back('{addr: addr, data: wd, acc: ncyc});
    else if (expect_rsp) rq.push_back('{rdata: er, perr: ep, cnt: ec, acc: ncyc});
    @(posedge pclk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((rq.size() != 0 || wq.size() != 0 || !req_ready) && budget < 200) begin
      @(negedge pclk); budget++;
    end
    check("drain_timeout", rq.size() + wq.size(), 0);
    @(posedge pclk); #1;
  endtask

  initial begin
    int a;
    int budget;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int budget;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge pclk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_addr", {16'd0, mem_address}, 32'd0);
    check("rst_perr_count", {30'd0, perr_count}, 32'd0);
    @(posedge pclk); #1;

    // Single write: one-cycle pulse, ready again 3 cycles after accept
    do_cmd(1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, a);
    @(negedge pclk);
    check("w1_pulse", {31'd0, mem_write}, 32'd1);
    check("w1_ready_lo1", {31'd0, req_ready}, 32'd0);
    @(negedge pclk);
    check("w1_pulse_end", {31'd0, mem_write}, 32'd0);
    check("w1_ready_lo2", {31'd0, req_ready}, 32'd0);
    @(negedge pclk);
    check("w1_ready_back", {31'd0, req_ready}, 32'd1);
    @(posedge pclk); #1;

    // Write then read back, with strobe timing
    do_cmd(1'b1, 16'h0001, 8'h3C, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, a);
    wait_drain();
    do_cmd(1'b0, 16'h0001, 8'h00, 8'h3C, 1'b0, 2'd0, 1'b1, 1'b0, a);
    repeat (L) @(negedge pclk);
    check("rd_level_last", {31'd0, mem_read}, 32'd1);
    @(negedge pclk);
    check("rd_gap_low", {31'd0, mem_read}, 32'd0);
    check("rd_gap_novalid", {31'd0, rsp_valid}, 32'd0);
    wait_drain();

    // Parity: 0x107 has four ones (good), 0x007 has three (bad); counter saturates at 3
    force_en = 1'b1; force_val = 9'h107;
    do_cmd(1'b0, 16'h0001, 8'h00, 8'h07, 1'b0, 2'd0, 1'b1, 1'b0, a);
    wait_drain();
    force_val = 9'h007;
    do_cmd(1'b0, 16'h0001, 8'h00, 8'h07, 1'b1, 2'd1, 1'b1, 1'b0, a);
    wait_drain();
    force_en = 1'b0;
    do_cmd(1'b0, 16'h0001, 8'h00, 8'h3C, 1'b0, 2'd1, 1'b1, 1'b0, a);
    wait_drain();
    force_en = 1'b1; force_val = 9'h0FE;
    do_cmd(1'b0, 16'h0001, 8'h00, 8'hFE, 1'b1, 2'd2, 1'b1, 1'b0, a);
    wait_drain();
    do_cmd(1'b0, 16'h0001, 8'h00, 8'hFE, 1'b1, 2'd3, 1'b1, 1'b0, a);
    wait_drain();
    do_cmd(1'b0, 16'h0001, 8'h00, 8'hFE, 1'b1, 2'd3, 1'b1, 1'b0, a);
    wait_drain();
    force_en = 1'b0;

    // Back-pressure: response held 10 cycles with nothing else moving
    rsp_ready = 1'b0;
    do_cmd(1'b0, 16'h0001, 8'h00, 8'h3C, 1'b0, 2'd3, 1'b1, 1'b0, a);
    budget = 0;
    @(negedge pclk);
    while (!rsp_valid && budget < 40) begin budget++; @(negedge pclk); end
    check("hold_reached", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", {24'd0, rsp_rdata}, 32'h3C);
      check("hold_no_accept", {31'd0, req_ready}, 32'd0);
      check("hold_no_strobe", {30'd0, mem_write, mem_read}, 32'd0);
    end
    @(posedge pclk); #1;
    rsp_ready = 1'b1;
    wait_drain();

    // Back-to-back writes with req_valid held high, then read both back
    do_cmd(1'b1, 16'h0002, 8'h11, 8'h00, 1'b0, 2'd3, 1'b0, 1'b1, a);
    do_cmd(1'b1, 16'h0003, 8'h80, 8'h00, 1'b0, 2'd3, 1'b0, 1'b0, a);
    wait_drain();
    do_cmd(1'b0, 16'h0002, 8'h00, 8'h11, 1'b0, 2'd3, 1'b1, 1'b0, a);
    wait_drain();
    do_cmd(1'b0, 16'h0003, 8'h00, 8'h80, 1'b0, 2'd3, 1'b1, 1'b0, a);
    wait_drain();

    // Reset during RD_WAIT: strobe drops, no response, counter cleared
    do_cmd(1'b0, 16'h0001, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, a);
    repeat (3) @(posedge pclk);
    #1 reset = 1'b1;
    @(negedge pclk);
    check("rst_mid_read_pre", {31'd0, mem_read}, 32'd1);
    @(posedge pclk); #1;
    @(negedge pclk);
    check("rst_mid_read_drop", {31'd0, mem_read}, 32'd0);
    check("rst_mid_perr_count", {30'd0, perr_count}, 32'd0);
    @(posedge pclk); #1 reset = 1'b0;
    repeat (L + 6) @(negedge pclk);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge pclk); #1;
    do_cmd(1'b0, 16'h0001, 8'h00, 8'h3C, 1'b0, 2'd0, 1'b1, 1'b0, a);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
